icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
// Instruction-side responder of datapath_cache_if. It answers datapath fetches (imemREN/imemaddr) with
// ihit/imemload from a direct-mapped, 2-word-block store. Misses are refilled from the memory controller
// over an iREN/iaddr/iwait/iload request port. It sits between the pipelined datapath and memory_control.
// PARAMETERS
// SETS      8   number of direct-mapped frames (power of 2, >=2)
// TAG_W     26  tag width = 32 - log2(SETS) - 3 (derived; do not override)
// PORTS
// CLK        in   1   clock, all state on rising edge
// RST        in   1   synchronous active-high reset
// imemREN    in   1   datapath fetch request
// imemaddr   in   32  fetch byte address (word aligned; [1:0] ignored)
// ihit       out  1   fetch satisfied this cycle
// imemload   out  32  instruction word; valid only when ihit=1
// iREN       out  1   refill read request to memory controller
// iaddr      out  32  refill word address
// iwait      in   1   memory busy; iload valid the cycle iwait=0 while iREN=1
// iload      in   32  refill data
// hit_count  out  32  number of cycles with ihit=1 (wraps)
// miss_count out  32  number of misses detected (wraps)
// BEHAVIOUR
// - Address split: tag=[31:31-TAG_W+1], idx=[log2(SETS)+2:3], blkoff=[2], byte=[1:0].
// - Frame: valid, tag, data[0:1]. Reset (RST=1 at edge): all valid=0, state IDLE, both counters 0.
//   Outputs during/after reset: ihit=0, iREN=0, iaddr=0, imemload=0 unless hit.
// - FSM states IDLE, FETCH0, FETCH1.
// - IDLE: hit = imemREN & valid[idx] & tag match. On hit, ihit=1 combinationally (zero-latency), and
//   imemload = data[idx][blkoff]. On miss, latch {tag,idx} to miss_addr, miss_count++, go FETCH0.
//   No iREN is asserted in IDLE.
// - FETCH0: iREN=1, iaddr={miss_addr,3'b000}. Hold while iwait=1. When iwait=0, write iload to
//   data[0] and go FETCH1.
// - FETCH1: iREN=1, iaddr={miss_addr,3'b100}. When iwait=0, write iload to data[1], set tag and
//   valid=1, go IDLE. The retried fetch hits on the next cycle.
// - Miss penalty: 2 + total iwait cycles before the first hit cycle. ihit=0 in FETCH0/FETCH1.
// - A refill, once started, always completes for the latched miss_addr, even if imemREN drops or
//   imemaddr changes mid-refill. The current address is looked up again in IDLE.
// - The refill overwrites the frame unconditionally; there is no dirty state. valid=0 during refill
//   is not required because ihit is suppressed outside IDLE.
// - imemREN=0 in IDLE: ihit=0, no state change, no counter change.
// - RST asserted in any state aborts the refill: state IDLE, all frames invalid.
// - hit_count increments every cycle that ihit=1 (the datapath may hold a hit across stalls).
// STRUCTURE
// - Use word_t from cpu_types_pkg. Add icache_frame_t (valid, tag, data[2]) and icache_state_t
//   (IDLE/FETCH0/FETCH1) to cpu_types_pkg so the dcache and the bench share them.
// - Single module. The frame array is a flat register array (no SRAM macro), with no sub-module.
// TESTING
// - Reset, then imemREN=1, imemaddr=0x00, iwait=0: iREN with iaddr=0x00, then 0x04;
//   ihit=1 on the 3rd cycle; miss_count=1.
// - Next, imemaddr=0x04: ihit=1 in the same cycle, imemload = word fetched at 0x04, iREN=0.
// - Conflict: fetch 0x40 (same idx 0, new tag): refill 0x40/0x44. A re-fetch of 0x00 then misses
//   again; miss_count=3.
// - iwait held 1 for 5 cycles in FETCH0: iaddr stays 0x00, ihit stays 0; first hit at cycle 8.
// - imemaddr changed to 0x20 during FETCH1 of 0x00: refill completes for 0x00, then a miss on 0x20
//   refills 0x20/0x24.
// - RST pulsed during FETCH0: iREN=0 next cycle, and the fetch of 0x00 misses again.
// - imemREN=0 for 10 cycles: ihit=0, iREN=0, and both counters are unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath/cache types: machine word, icache frame layout and
// icache refill FSM states (also used by the dcache and the bench).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Widest tag any legal set count can need (SETS=2 -> 32-1-3 = 28 bits).
  // Narrower configurations zero-extend their tag into this field.
  localparam int ICACHE_TAG_MAX_W = 28;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    word_t [1:0]                 data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_responder.sv
// Instruction cache responder: direct-mapped, 2-word blocks, zero-latency
// hits in IDLE, two-beat refill from the memory controller on a miss.
module icache_responder
  import cpu_types_pkg::*;
#(
  parameter  int SETS  = 8,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 32 - IDX_W - 3,
  localparam int BLK_W = TAG_W + IDX_W
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  icache_frame_t [SETS-1:0] frames_q, frames_d;
  icache_state_t            state_q, state_d;
  logic [BLK_W-1:0]         miss_addr_q, miss_addr_d;
  logic                     iren_q, iren_d;
  word_t                    iaddr_q, iaddr_d;
  word_t                    hit_count_q, hit_count_d;
  word_t                    miss_count_q, miss_count_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             req_off;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             lookup_hit;
  logic             unused_byte_bits;

  assign req_tag  = imemaddr[31 -: TAG_W];
  assign req_idx  = imemaddr[IDX_W+2:3];
  assign req_off  = imemaddr[2];
  assign fill_tag = miss_addr_q[BLK_W-1 -: TAG_W];
  assign fill_idx = miss_addr_q[IDX_W-1:0];

  // Byte offset within the word is irrelevant to word fetches.
  assign unused_byte_bits = ^imemaddr[1:0];

  // Lookup only answers in IDLE; refill states suppress hits, so a frame
  // being overwritten never needs to be invalidated first.
  assign lookup_hit = (state_q == IDLE) && imemREN && frames_q[req_idx].valid &&
                      (frames_q[req_idx].tag == ICACHE_TAG_MAX_W'(req_tag));

  assign ihit       = lookup_hit && !RST;
  assign imemload   = ihit ? frames_q[req_idx].data[req_off] : '0;
  assign iREN       = iren_q;
  assign iaddr      = iaddr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Next-state: miss detection, two-beat refill, statistics counters.
  always_comb begin
    state_d      = state_q;
    frames_d     = frames_q;
    miss_addr_d  = miss_addr_q;
    iren_d       = iren_q;
    iaddr_d      = iaddr_q;
    hit_count_d  = hit_count_q + 32'(ihit);
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          // Latch the block so the refill finishes even if the fetch moves.
          miss_addr_d  = imemaddr[31:3];
          miss_count_d = miss_count_q + 32'd1;
          iren_d       = 1'b1;
          iaddr_d      = {imemaddr[31:3], 3'b000};
          state_d      = FETCH0;
        end
      end
      FETCH0: begin
        if (!iwait) begin
          frames_d[fill_idx].data[0] = iload;
          iaddr_d                    = {miss_addr_q, 3'b100};
          state_d                    = FETCH1;
        end
      end
      FETCH1: begin
        if (!iwait) begin
          frames_d[fill_idx].data[1] = iload;
          frames_d[fill_idx].tag     = ICACHE_TAG_MAX_W'(fill_tag);
          frames_d[fill_idx].valid   = 1'b1;
          iren_d                     = 1'b0;
          iaddr_d                    = '0;
          state_d                    = IDLE;
        end
      end
      default: begin
        iren_d  = 1'b0;
        iaddr_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any refill and invalidates every frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      frames_q     <= '0;
      miss_addr_q  <= '0;
      iren_q       <= 1'b0;
      iaddr_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      frames_q     <= frames_d;
      miss_addr_q  <= miss_addr_d;
      iren_q       <= iren_d;
      iaddr_q      <= iaddr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus random fetch traffic,
// checked against a block-level cache model and an address-hashed memory.
module tb_icache_responder;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hit_count;
  word_t miss_count;

  int n_tests = 0;
  int n_fail  = 0;
  word_t seed;

  // Reference model: which 8-byte block each of the 8 sets holds.
  bit          mv   [8];
  logic [28:0] mblk [8];
  word_t       m_hits, m_misses;

  icache_responder dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem_word(word_t a);
    word_t w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ seed ^ 32'h5A5A_0000;
  endfunction

  // Memory controller: data only when not busy; garbage otherwise.
  assign iload = (iREN && !iwait) ? mem_word(iaddr) : (32'hDEAD_BEEF ^ seed);

  function automatic bit m_lookup(word_t a);
    return mv[a[5:3]] && (mblk[a[5:3]] == a[31:3]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) begin
      mv[i]   = 1'b0;
      mblk[i] = '0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One datapath fetch: hit in place, or a full refill with the given
  // busy cycles per beat; optionally move the fetch address during FETCH1.
  task automatic do_fetch(input word_t a, input int w0, input int w1,
                          input bit chg, input word_t new_a, input string nm);
    word_t base;
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b0;
    base     = {a[31:3], 3'b000};
    @(negedge CLK);
    if (m_lookup(a)) begin
      n_tests++;
      if (ihit !== 1'b1 || imemload !== mem_word(a) || iREN !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hit a=%h: ihit=%b load=%h iREN=%b want 1 %h 0",
                 nm, a, ihit, imemload, iREN, mem_word(a));
      end
      m_hits++;
      next_cycle();
    end else begin
      n_tests++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
        n_fail++;
        $display("FAIL %s miss_detect a=%h: ihit=%b iREN=%b want 0 0", nm, a, ihit, iREN);
      end
      m_misses++;
      next_cycle();
      for (int i = 0; i <= w0; i++) begin
        iwait = (i < w0);
        @(negedge CLK);
        n_tests++;
        if (iREN !== 1'b1 || iaddr !== base || ihit !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fetch0 a=%h: iREN=%b iaddr=%h ihit=%b want 1 %h 0",
                   nm, a, iREN, iaddr, ihit, base);
        end
        next_cycle();
      end
      for (int i = 0; i <= w1; i++) begin
        iwait = (i < w1);
        if (chg) imemaddr = new_a;
        @(negedge CLK);
        n_tests++;
        if (iREN !== 1'b1 || iaddr !== (base | 32'h4) || ihit !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fetch1 a=%h: iREN=%b iaddr=%h ihit=%b want 1 %h 0",
                   nm, a, iREN, iaddr, ihit, base | 32'h4);
        end
        next_cycle();
      end
      iwait         = 1'b0;
      mv[a[5:3]]    = 1'b1;
      mblk[a[5:3]]  = a[31:3];
      if (!chg) begin
        @(negedge CLK);
        n_tests++;
        if (ihit !== 1'b1 || imemload !== mem_word(a) || iREN !== 1'b0) begin
          n_fail++;
          $display("FAIL %s refill_hit a=%h: ihit=%b load=%h iREN=%b want 1 %h 0",
                   nm, a, ihit, imemload, iREN, mem_word(a));
        end
        m_hits++;
        next_cycle();
      end
    end
    n_tests++;
    if (hit_count !== m_hits || miss_count !== m_misses) begin
      n_fail++;
      $display("FAIL %s counters: hit=%0d miss=%0d want %0d %0d",
               nm, hit_count, miss_count, m_hits, m_misses);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b1; imemaddr = '0; iwait = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_tests++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== '0 || imemload !== '0 ||
        hit_count !== '0 || miss_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ihit=%b iREN=%b iaddr=%h load=%h hc=%0d mc=%0d",
               ihit, iREN, iaddr, imemload, hit_count, miss_count);
    end
    next_cycle();
    RST = 1'b0; imemREN = 1'b0;
    m_clear();
    @(negedge CLK);
    n_tests++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ihit=%b iREN=%b want 0 0", ihit, iREN);
    end
    next_cycle();
  endtask

  task automatic test_first_miss();
    do_fetch(32'h00, 0, 0, 1'b0, '0, "first_miss");
    n_tests++;
    if (miss_count !== 32'd1) begin
      n_fail++;
      $display("FAIL first_miss_count: miss_count=%0d want 1", miss_count);
    end
  endtask

  task automatic test_same_block();
    do_fetch(32'h04, 0, 0, 1'b0, '0, "same_block");
  endtask

  task automatic test_conflict();
    do_fetch(32'h40, 0, 0, 1'b0, '0, "conflict_40");
    do_fetch(32'h00, 0, 0, 1'b0, '0, "conflict_00");
    n_tests++;
    if (miss_count !== 32'd3) begin
      n_fail++;
      $display("FAIL conflict_count: miss_count=%0d want 3", miss_count);
    end
  endtask

  task automatic test_iwait();
    do_fetch(32'h40, 0, 0, 1'b0, '0, "iwait_evict");
    do_fetch(32'h00, 5, 0, 1'b0, '0, "iwait_5");
  endtask

  task automatic test_addr_change();
    do_fetch(32'h40, 0, 0, 1'b0, '0, "chg_evict");
    do_fetch(32'h00, 0, 1, 1'b1, 32'h20, "chg_00");
    do_fetch(32'h20, 0, 0, 1'b0, '0, "chg_20");
    do_fetch(32'h24, 0, 0, 1'b0, '0, "chg_24");
    do_fetch(32'h00, 0, 0, 1'b0, '0, "chg_00_again");
  endtask

  task automatic test_reset_mid();
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_miss: ihit=%b want 0", ihit);
    end
    next_cycle();
    iwait = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (iREN !== 1'b1 || iaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL rst_mid_fetch0: iREN=%b iaddr=%h want 1 00000040", iREN, iaddr);
    end
    next_cycle();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0; iwait = 1'b0; imemREN = 1'b0;
    m_clear();
    @(negedge CLK);
    n_tests++;
    if (iREN !== 1'b0 || iaddr !== '0 || hit_count !== '0 || miss_count !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: iREN=%b iaddr=%h hc=%0d mc=%0d want 0 0 0 0",
               iREN, iaddr, hit_count, miss_count);
    end
    next_cycle();
    do_fetch(32'h00, 0, 0, 1'b0, '0, "rst_mid_refetch");
  endtask

  task automatic test_idle();
    word_t hc0, mc0;
    hc0 = hit_count;
    mc0 = miss_count;
    imemREN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      imemaddr = (i % 2 == 0) ? 32'h00 : $urandom;
      @(negedge CLK);
      n_tests++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_out cyc=%0d: ihit=%b iREN=%b want 0 0", i, ihit, iREN);
      end
      next_cycle();
    end
    n_tests++;
    if (hit_count !== hc0 || miss_count !== mc0 ||
        hit_count !== m_hits || miss_count !== m_misses) begin
      n_fail++;
      $display("FAIL idle_counters: hc=%0d mc=%0d want %0d %0d",
               hit_count, miss_count, m_hits, m_misses);
    end
  endtask

  task automatic test_random();
    word_t tags [3];
    word_t a;
    tags[0] = 32'h0;
    tags[1] = 32'h1;
    tags[2] = 32'h03FF_FFFF;
    for (int n = 0; n < 60; n++) begin
      a = (tags[$urandom_range(0, 2)] << 6) | (32'($urandom_range(0, 7)) << 3) |
          (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
      do_fetch(a, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, '0, "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = $urandom;
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b0;
    m_clear();
    #1;
    test_reset();
    test_first_miss();
    test_same_block();
    test_conflict();
    test_iwait();
    test_addr_change();
    test_reset_mid();
    test_idle();
    test_random();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
